serial_pattern_transmitter: RTL and testbench



---
 rtl/serial_pattern_transmitter.sv | 138 +++++++++++++
 tb/tb_serial_pattern_transmitter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_transmitter.sv
// rtl/serial_pattern_transmitter.sv - MSB-first serial pattern source with programmable word repetition
// Optional build macro SPT_PARITY_EN appends an even-parity bit after every word.
module serial_pattern_transmitter #(
    parameter int WIDTH = 4,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic             out_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

`ifdef SPT_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t             state;
    // shreg holds the bits still to come after the one currently on out
    logic [WIDTH-2:0]   shreg;
    logic [WIDTH-1:0]   pat;
    logic [CW-1:0]      bitcnt;
    logic [REP_W-1:0]   repcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            pat       <= '0;
            bitcnt    <= '0;
            repcnt    <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        pat       <= pattern;
                        shreg     <= pattern[WIDTH-2:0];
                        bitcnt    <= CW'(WIDTH - 1);
                        repcnt    <= (reps == '0) ? REP_W'(1) : reps;
                        out       <= pattern[WIDTH-1];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (out_ready) begin
                        if (bitcnt != '0) begin
                            out    <= shreg[WIDTH-2];
                            shreg  <= shreg << 1;
                            bitcnt <= bitcnt - 1'b1;
`ifdef SPT_PARITY_EN
                            out_last <= 1'b0;
`else
                            out_last <= (bitcnt == CW'(1));
`endif
                        end else begin
`ifdef SPT_PARITY_EN
                            state    <= PARITY;
                            out      <= ^pat;
                            out_last <= 1'b1;
`else
                            // next word starts on the very next beat, from the captured copy
                            if (repcnt > REP_W'(1)) begin
                                repcnt   <= repcnt - 1'b1;
                                shreg    <= pat[WIDTH-2:0];
                                bitcnt   <= CW'(WIDTH - 1);
                                out      <= pat[WIDTH-1];
                                out_last <= 1'b0;
                            end else begin
                                state     <= DONE;
                                out       <= 1'b0;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                done      <= 1'b1;
                            end
`endif
                        end
                    end
                end

`ifdef SPT_PARITY_EN
                PARITY: begin
                    if (out_ready) begin
                        if (repcnt > REP_W'(1)) begin
                            state    <= SHIFT;
                            repcnt   <= repcnt - 1'b1;
                            shreg    <= pat[WIDTH-2:0];
                            bitcnt   <= CW'(WIDTH - 1);
                            out      <= pat[WIDTH-1];
                            out_last <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// tb/tb_serial_pattern_transmitter.sv - bench for serial_pattern_transmitter
// Honours SPT_PARITY_EN when defined for the build.
module tb_serial_pattern_transmitter;

    localparam int WIDTH = 4;
    localparam int REP_W = 3;
`ifdef SPT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [REP_W-1:0] reps = '0;
    logic             out_ready = 1'b1;
    logic             out, out_valid, out_last, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;

    serial_pattern_transmitter #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
        .out_ready(out_ready), .out(out), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    endtask

    // Model: a burst is just a queue of {bit,last} entries; each beat pops one.
    logic [1:0] q[$];
    bit m_busy = 0;
    bit m_done = 0;
    bit live = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_busy = 0;
            m_done = 0;
            live = 1;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            if (out_ready && q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1;
            end
        end else if (start) begin
            int r;
            r = (reps == 0) ? 1 : int'(reps);
            for (int k = 0; k < r; k++) begin
                for (int i = WIDTH - 1; i >= 0; i--)
                    q.push_back({pattern[i], (i == 0) && !PAR});
                if (PAR) q.push_back({^pattern, 1'b1});
            end
            m_busy = 1;
        end
    end

    logic [4:0] exp_v, act_v;
    always @(negedge clk) begin
        if (live) begin
            if (q.size() > 0) exp_v = {q[0][1], 1'b1, q[0][0], m_busy, m_done};
            else              exp_v = {3'b000, m_busy, m_done};
            act_v = {out, out_valid, out_last, busy, done};
            check("cycle_model", 32'(act_v), 32'(exp_v));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int nbits, ndone, done_at, idle_at;
    logic [31:0] bits, lasts;

    task automatic burst(input logic [3:0] p, input logic [2:0] r, input logic [7:0] rdy,
                         input int ncyc, input int poke_at);
        bits = '0; lasts = '0; nbits = 0; ndone = 0; done_at = -1; idle_at = -1;
        pattern = p; reps = r; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            out_ready = rdy[c % 8];
            if (c == poke_at) begin
                start = 1'b1;
                pattern = 4'b0000;
                reps = 3'd5;
            end else begin
                start = 1'b0;
            end
            if (out_valid && out_ready) begin
                bits = {bits[30:0], out};
                lasts = {lasts[30:0], out_last};
                nbits++;
            end
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (!busy && idle_at < 0) idle_at = c;
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check("reset_outputs", 32'({out, out_valid, out_last, busy, done}), 32'd0);
        rst = 1'b0;
        tick();

        // single word, reps=0 treated as 1
        burst(4'b0111, 3'd0, 8'hFF, 10, -1);
        check("single_bits", bits, PAR ? 32'hF : 32'h7);
        check("single_nbits", 32'(nbits), PAR ? 32'd5 : 32'd4);
        check("single_last", lasts, 32'h1);
        check("single_done_at", 32'(done_at), PAR ? 32'd5 : 32'd4);
        check("single_idle_at", 32'(idle_at), PAR ? 32'd6 : 32'd5);
        check("single_ndone", 32'(ndone), 32'd1);

        // three repetitions, no gap
        burst(4'b1100, 3'd3, 8'hFF, 20, -1);
        check("rep_bits", bits, PAR ? 32'h6318 : 32'hCCC);
        check("rep_last", lasts, PAR ? 32'h421 : 32'h111);
        check("rep_done_at", 32'(done_at), PAR ? 32'd15 : 32'd12);
        check("rep_ndone", 32'(ndone), 32'd1);

        // backpressure 1,0,0,1,...
        burst(4'b1011, 3'd1, 8'h99, 24, -1);
        check("bp_bits", bits, PAR ? 32'h17 : 32'hB);
        check("bp_nbits", 32'(nbits), PAR ? 32'd5 : 32'd4);
        check("bp_last", lasts, 32'h1);
        check("bp_ndone", 32'(ndone), 32'd1);

        // plain 1011 with ready high
        burst(4'b1011, 3'd1, 8'hFF, 8, -1);
        check("w1011_bits", bits, PAR ? 32'h17 : 32'hB);
        check("w1011_done_at", 32'(done_at), PAR ? 32'd5 : 32'd4);

        // start and pattern change while busy are ignored
        burst(4'b1100, 3'd2, 8'hFF, 16, 2);
        check("ign_bits", bits, PAR ? 32'h318 : 32'hCC);
        check("ign_nbits", 32'(nbits), PAR ? 32'd10 : 32'd8);
        check("ign_last", lasts, PAR ? 32'h21 : 32'h11);
        check("ign_ndone", 32'(ndone), 32'd1);

        // maximum repetition count
        burst(4'b1001, 3'd7, 8'hFF, 40, -1);
        check("max_nbits", 32'(nbits), PAR ? 32'd35 : 32'd28);
        check("max_done_at", 32'(done_at), PAR ? 32'd35 : 32'd28);
        check("max_ndone", 32'(ndone), 32'd1);

        // reset mid-burst after 3 beats
        pattern = 4'b1011; reps = 3'd2; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        tick();
        burst(4'b0111, 3'd1, 8'hFF, 10, -1);
        check("post_rst_bits", bits, PAR ? 32'hF : 32'h7);
        check("post_rst_ndone", 32'(ndone), 32'd1);

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
